// File: rtl/one_cold_encoder_if.sv
// one_cold_encoder_if: raw one-cold input lines and encoded outputs of the encoder
interface one_cold_encoder_if;
  logic [3:0] T_n;
  logic [1:0] idx;
  logic       valid;
  logic       err;
  logic       change;
  modport master (output T_n, input idx, valid, err, change);
  modport slave (input T_n, output idx, valid, err, change);
endinterface

// File: rtl/one_cold_encoder.sv
// one_cold_encoder: synchronise, debounce and encode an active-low one-cold bus to a 2-bit index
module one_cold_encoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  one_cold_encoder_if.slave bus
);
  typedef enum logic [1:0] {NONE, ONE, MULTI} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [3:0] sync1, sync2, cand, committed, lo;
  logic [CNT_W-1:0] cnt;
  logic [1:0] idx_q, idx_nx;
  logic change_q, commit;
  state_t state, state_nx;
  assign commit = sync2 == cand && cnt == LAST && cand != committed;
  assign lo = ~cand;
  // two-flop synchroniser, then a candidate code must stay put long enough to be committed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
      cand <= 4'b1111;
      committed <= 4'b1111;
      cnt <= '0;
    end else begin
      sync1 <= bus.T_n;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt <= '0;
      end else if (cnt < LAST) cnt <= cnt + 1'b1;
      else if (cand != committed) committed <= cand;
    end
  // classify the code being committed; idx only moves for a legal one-cold code
  always_comb begin
    state_nx = state;
    idx_nx = idx_q;
    if (commit) begin
      state_nx = lo == 4'd0 ? NONE : (lo & (lo - 4'd1)) == 4'd0 ? ONE : MULTI;
      idx_nx = state_nx == ONE ? {lo[3] | lo[2], lo[3] | lo[1]} : idx_q;
    end
  end
  // valid/err are decoded from the state, so a change in state or idx is an output change
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= NONE;
      idx_q <= 2'd0;
      change_q <= 1'b0;
    end else begin
      state <= state_nx;
      idx_q <= idx_nx;
      change_q <= state_nx != state || idx_nx != idx_q;
    end
  assign bus.idx = idx_q;
  assign bus.valid = state == ONE;
  assign bus.err = state == MULTI;
  assign bus.change = change_q;
endmodule

// File: tb/tb_one_cold_encoder.sv
// tb_one_cold_encoder: directed and random stimulus against a queue-based reference model
module tb_one_cold_encoder;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int p0;
  logic [3:0] inq[$];
  logic [3:0] obsq[$];
  logic [3:0] m_comm;
  logic [1:0] m_idx;
  logic m_valid, m_err, m_change;
  one_cold_encoder_if bus ();
  one_cold_encoder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic void m_reset();
    inq = {4'hF, 4'hF};
    obsq = {};
    m_comm = 4'hF;
    m_idx = 2'd0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_change = 1'b0;
  endfunction
  // a code commits once SC+1 consecutive synchronised samples agree and it differs from the last commit
  function automatic void m_edge(logic [3:0] t);
    logic [3:0] o;
    logic [1:0] pi;
    logic v, e, eq;
    int z;
    o = inq.pop_front();
    inq.push_back(t);
    obsq.push_back(o);
    if (obsq.size() > SC + 1) void'(obsq.pop_front());
    eq = 1'b1;
    foreach (obsq[i]) eq &= obsq[i] == o;
    m_change = 1'b0;
    if (obsq.size() == SC + 1 && eq && o != m_comm) begin
      m_comm = o;
      z = 4 - $countones(o);
      v = z == 1;
      e = z > 1;
      pi = m_idx;
      if (v) for (int i = 0; i < 4; i++) if (!o[i]) pi = i[1:0];
      m_change = {pi, v, e} != {m_idx, m_valid, m_err};
      m_idx = pi;
      m_valid = v;
      m_err = e;
    end
  endfunction
  task automatic step(logic [3:0] v, int n, string tag);
    for (int k = 0; k < n; k++) begin
      bus.T_n = v;
      @(posedge clk);
      m_edge(v);
      #1;
      chk({tag, ".idx"}, bus.idx, m_idx);
      chk({tag, ".valid"}, bus.valid, m_valid);
      chk({tag, ".err"}, bus.err, m_err);
      chk({tag, ".change"}, bus.change, m_change);
      pulses += int'(bus.change);
    end
  endtask
  initial begin
    bus.T_n = 4'b0111;
    m_reset();
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("rst.idx", bus.idx, 4'd0);
      chk("rst.valid", bus.valid, 4'd0);
      chk("rst.err", bus.err, 4'd0);
      chk("rst.change", bus.change, 4'd0);
    end
    bus.T_n = 4'hF;
    rst = 1'b0;
    step(4'hF, 3, "idle");
    p0 = pulses;
    step(4'b1011, 6, "press");
    chk("press.early_valid", bus.valid, 4'd0);
    step(4'b1011, 1, "press");
    chk("press.edge7_idx", bus.idx, 4'd2);
    chk("press.edge7_valid", bus.valid, 4'd1);
    chk("press.edge7_change", bus.change, 4'd1);
    step(4'b1011, 1, "press");
    chk("press.change_once", bus.change, 4'd0);
    step(4'b1011, 3, "press");
    step(4'hF, 7, "release");
    chk("release.valid", bus.valid, 4'd0);
    chk("release.idx", bus.idx, 4'd2);
    step(4'hF, 3, "release");
    chk("press.pulses", 4'(pulses - p0), 4'd2);
    p0 = pulses;
    step(4'b1101, 3, "glitch");
    step(4'hF, 10, "glitch");
    chk("glitch.pulses", 4'(pulses - p0), 4'd0);
    chk("glitch.valid", bus.valid, 4'd0);
    p0 = pulses;
    step(4'b0110, 10, "illegal");
    chk("illegal.err", bus.err, 4'd1);
    chk("illegal.valid", bus.valid, 4'd0);
    chk("illegal.idx", bus.idx, 4'd2);
    chk("illegal.pulses", 4'(pulses - p0), 4'd1);
    p0 = pulses;
    step(4'b0101, 10, "multi");
    chk("multi.err", bus.err, 4'd1);
    chk("multi.pulses", 4'(pulses - p0), 4'd0);
    p0 = pulses;
    step(4'b1110, 10, "walk0");
    chk("walk0.idx", bus.idx, 4'd0);
    step(4'b1101, 10, "walk1");
    chk("walk1.idx", bus.idx, 4'd1);
    step(4'b1011, 10, "walk2");
    chk("walk2.idx", bus.idx, 4'd2);
    step(4'b0111, 10, "walk3");
    chk("walk3.idx", bus.idx, 4'd3);
    chk("walk.pulses", 4'(pulses - p0), 4'd4);
    step(4'hF, 10, "clear");
    step(4'b0111, 5, "settle");
    #2 rst = 1'b1;
    #1;
    chk("arst.idx", bus.idx, 4'd0);
    chk("arst.valid", bus.valid, 4'd0);
    chk("arst.err", bus.err, 4'd0);
    chk("arst.change", bus.change, 4'd0);
    rst = 1'b0;
    m_reset();
    step(4'b0111, 6, "arst");
    chk("arst.no_early", bus.valid, 4'd0);
    step(4'b0111, 1, "arst");
    chk("arst.edge7_idx", bus.idx, 4'd3);
    chk("arst.edge7_valid", bus.valid, 4'd1);
    for (int s = 0; s < 150; s++)
      step(4'($urandom_range(0, 15)), int'($urandom_range(1, 9)), "rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
